// File: rtl/spi_burst_controller.sv
// Byte-wide SPI command front end: register file, matcher stream forwarding,
// burst read/write with auto-increment, and a result FIFO with overflow status.
module spi_burst_controller #(
    parameter int NUM_CHARS    = 8,
    parameter int RESULT_DEPTH = 8
) (
    input  logic                   sclk,
    input  logic                   rst,
    input  logic                   cs,
    input  logic [7:0]             mosi,
    output logic [7:0]             miso,
    output logic [7:0]             word_size,
    output logic [7:0]             result_mask,
    output logic [8*NUM_CHARS-1:0] characters,
    output logic [8*NUM_CHARS-1:0] masks,
    output logic                   aclk,
    output logic                   aresetn,
    output logic                   m_axis_tvalid,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tuser,
    input  logic                   s_axis_tvalid,
    input  logic [7:0]             s_axis_tdata
);

    localparam int CW = $clog2(NUM_CHARS);
    localparam int FW = $clog2(RESULT_DEPTH);
    localparam int NW = FW + 1;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_RD_ADDR = 4'd1;
    localparam logic [3:0] ST_WR_ADDR = 4'd2;
    localparam logic [3:0] ST_WR_DATA = 4'd3;
    localparam logic [3:0] ST_BR_ADDR = 4'd4;
    localparam logic [3:0] ST_BR_CNT  = 4'd5;
    localparam logic [3:0] ST_BR_DATA = 4'd6;
    localparam logic [3:0] ST_BW_ADDR = 4'd7;
    localparam logic [3:0] ST_BW_CNT  = 4'd8;
    localparam logic [3:0] ST_BW_DATA = 4'd9;

    logic [3:0]    state;
    logic [1:0]    area;
    logic [5:0]    addr;
    logic [7:0]    remaining;
    logic [7:0]    chars_r [NUM_CHARS];
    logic [7:0]    masks_r [NUM_CHARS];

    logic [7:0]    fifo_mem [RESULT_DEPTH];
    logic [FW-1:0] rd_ptr;
    logic [FW-1:0] wr_ptr;
    logic [NW-1:0] count;
    logic          overflow;

    logic          accept;
    logic [1:0]    acc_area;
    logic [5:0]    acc_idx;
    logic          load_miso;
    logic          do_write;
    logic          fifo_empty;
    logic          pop;
    logic          flush;
    logic          push_ok;
    logic [7:0]    rd_data;
    logic [7:0]    status;

    function automatic logic [5:0] sat_count(input logic [NW-1:0] c);
        if (int'(c) > 63)
            return 6'd63;
        return 6'(c);
    endfunction

    assign aclk = sclk;

    for (genvar g = 0; g < NUM_CHARS; g++) begin : g_pack
        assign characters[8*g +: 8] = chars_r[g];
        assign masks[8*g +: 8]      = masks_r[g];
    end

    assign accept     = !cs;
    assign fifo_empty = (count == '0);
    assign status     = {overflow, fifo_empty, sat_count(count)};

    // A single READ targets the byte being accepted; everything else uses the latched address.
    assign acc_area  = (state == ST_RD_ADDR) ? mosi[7:6] : area;
    assign acc_idx   = (state == ST_RD_ADDR) ? mosi[5:0] : addr;
    assign load_miso = accept && ((state == ST_RD_ADDR) || (state == ST_BR_DATA) ||
                                  ((state == ST_BR_CNT) && (mosi != 8'd0)));
    assign do_write  = accept && ((state == ST_WR_DATA) || (state == ST_BW_DATA));
    assign pop       = load_miso && (acc_area == 2'b11) && !fifo_empty;
    assign flush     = do_write && (area == 2'b00) && (addr == 6'd3) && mosi[0];
    assign push_ok   = s_axis_tvalid && !flush && ((count < NW'(RESULT_DEPTH)) || pop);

    always_comb begin
        rd_data = 8'h00;
        case (acc_area)
            2'b00: begin
                case (acc_idx)
                    6'd0:    rd_data = word_size;
                    6'd1:    rd_data = result_mask;
                    6'd2:    rd_data = status;
                    default: rd_data = 8'h00;
                endcase
            end
            2'b01:   rd_data = chars_r[acc_idx[CW-1:0]];
            2'b10:   rd_data = masks_r[acc_idx[CW-1:0]];
            default: rd_data = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
        endcase
    end

    always_ff @(posedge sclk) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= s_axis_tdata;
    end

    always_ff @(posedge sclk) begin
        if (rst || flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            else if (s_axis_tvalid)
                overflow <= 1'b1;
            count <= count + {{(NW-1){1'b0}}, push_ok} - {{(NW-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state         <= ST_IDLE;
            area          <= 2'b00;
            addr          <= 6'd0;
            remaining     <= 8'd0;
            miso          <= 8'h00;
            word_size     <= 8'h00;
            result_mask   <= 8'h00;
            aresetn       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 8'h00;
            m_axis_tuser  <= 1'b0;
            for (int i = 0; i < NUM_CHARS; i++) begin
                chars_r[i] <= 8'h00;
                masks_r[i] <= 8'h00;
            end
        end else begin
            m_axis_tvalid <= 1'b0;
            if (!accept) begin
                state <= ST_IDLE;
            end else begin
                if (load_miso)
                    miso <= rd_data;
                if (do_write) begin
                    case (area)
                        2'b00: begin
                            if (addr == 6'd0)
                                word_size <= mosi;
                            else if (addr == 6'd1)
                                result_mask <= mosi;
                        end
                        2'b01:   chars_r[addr[CW-1:0]] <= mosi;
                        2'b10:   masks_r[addr[CW-1:0]] <= mosi;
                        default: ;
                    endcase
                end
                case (state)
                    ST_IDLE: begin
                        case (mosi)
                            8'h00: ;
                            8'h01: begin
                                m_axis_tvalid <= 1'b1;
                                m_axis_tuser  <= 1'b1;
                                m_axis_tdata  <= 8'h01;
                            end
                            8'h02: state <= ST_RD_ADDR;
                            8'h03: state <= ST_WR_ADDR;
                            8'h04: aresetn <= 1'b1;
                            8'h05: aresetn <= 1'b0;
                            8'h06: state <= ST_BR_ADDR;
                            8'h07: state <= ST_BW_ADDR;
                            default: begin
                                if (aresetn) begin
                                    m_axis_tvalid <= 1'b1;
                                    m_axis_tuser  <= 1'b0;
                                    m_axis_tdata  <= mosi;
                                end
                            end
                        endcase
                    end
                    ST_RD_ADDR: state <= ST_IDLE;
                    ST_WR_ADDR, ST_BR_ADDR, ST_BW_ADDR: begin
                        area <= mosi[7:6];
                        addr <= mosi[5:0];
                        state <= (state == ST_WR_ADDR) ? ST_WR_DATA :
                                 (state == ST_BR_ADDR) ? ST_BR_CNT : ST_BW_CNT;
                    end
                    ST_WR_DATA: state <= ST_IDLE;
                    ST_BR_CNT: begin
                        // Count byte already loads the first word, so only count-1 dummies follow.
                        if (mosi == 8'd0) begin
                            state <= ST_IDLE;
                        end else begin
                            addr      <= addr + 6'd1;
                            remaining <= mosi - 8'd1;
                            state     <= (mosi == 8'd1) ? ST_IDLE : ST_BR_DATA;
                        end
                    end
                    ST_BW_CNT: begin
                        remaining <= mosi;
                        state     <= (mosi == 8'd0) ? ST_IDLE : ST_BW_DATA;
                    end
                    ST_BR_DATA, ST_BW_DATA: begin
                        addr      <= addr + 6'd1;
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_burst_controller.sv
// Scoreboard bench for spi_burst_controller: transaction-level reference model,
// expectation queues for miso and the matcher stream, directed plus random traffic.
module tb_spi_burst_controller;

    localparam int NUM_CHARS    = 8;
    localparam int RESULT_DEPTH = 8;

    logic                   sclk = 1'b0;
    logic                   rst;
    logic                   cs;
    logic [7:0]             mosi;
    logic [7:0]             miso;
    logic [7:0]             word_size;
    logic [7:0]             result_mask;
    logic [8*NUM_CHARS-1:0] characters;
    logic [8*NUM_CHARS-1:0] masks;
    logic                   aclk;
    logic                   aresetn;
    logic                   m_axis_tvalid;
    logic [7:0]             m_axis_tdata;
    logic                   m_axis_tuser;
    logic                   s_axis_tvalid;
    logic [7:0]             s_axis_tdata;

    spi_burst_controller #(.NUM_CHARS(NUM_CHARS), .RESULT_DEPTH(RESULT_DEPTH)) dut (
        .sclk(sclk), .rst(rst), .cs(cs), .mosi(mosi), .miso(miso),
        .word_size(word_size), .result_mask(result_mask),
        .characters(characters), .masks(masks), .aclk(aclk), .aresetn(aresetn),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata)
    );

    always #5 sclk = ~sclk;

    typedef struct { int e; logic [7:0] v; } miso_exp_t;
    typedef struct { int e; logic [7:0] d; logic u; } ax_exp_t;
    miso_exp_t miso_q[$];
    ax_exp_t   ax_q[$];

    int errors = 0;
    int checks = 0;
    int edge_no = 0;
    int push_mode = 0;

    // Reference model state
    logic [7:0] m_ws, m_rm, m_miso;
    logic [7:0] m_ch [NUM_CHARS];
    logic [7:0] m_mk [NUM_CHARS];
    logic [7:0] m_q[$];
    bit         m_ovf, m_en;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_no);
        end
    endtask

    function automatic void model_reset();
        m_ws = 0; m_rm = 0; m_miso = 0; m_ovf = 0; m_en = 0;
        m_q.delete();
        for (int i = 0; i < NUM_CHARS; i++) begin
            m_ch[i] = 0;
            m_mk[i] = 0;
        end
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        int idx = int'(a[5:0]);
        int n;
        case (a[7:6])
            2'b00: begin
                if (idx == 0) return m_ws;
                if (idx == 1) return m_rm;
                if (idx == 2) begin
                    n = m_q.size();
                    if (n > 63) n = 63;
                    return {m_ovf, (m_q.size() == 0), 6'(n)};
                end
                return 8'h00;
            end
            2'b01: return m_ch[idx % NUM_CHARS];
            2'b10: return m_mk[idx % NUM_CHARS];
            default: begin
                if (m_q.size() == 0) return 8'h00;
                return m_q.pop_front();
            end
        endcase
    endfunction

    function automatic bit model_write(input logic [7:0] a, input logic [7:0] d);
        int idx = int'(a[5:0]);
        case (a[7:6])
            2'b00: begin
                if (idx == 0) m_ws = d;
                if (idx == 1) m_rm = d;
                if (idx == 3) return d[0];
            end
            2'b01: m_ch[idx % NUM_CHARS] = d;
            2'b10: m_mk[idx % NUM_CHARS] = d;
            default: ;
        endcase
        return 1'b0;
    endfunction

    function automatic int area_size(input logic [1:0] ar);
        return (ar == 2'b01 || ar == 2'b10) ? NUM_CHARS : 64;
    endfunction

    // One sclk edge: drive at negedge, apply the model after the rising edge.
    task automatic tick(input bit csv, input logic [7:0] b, input bit rd, input logic [7:0] ra,
                        input bit wr, input logic [7:0] wa, input bit fwd, input logic [7:0] fd,
                        input bit fu);
        bit push, flush;
        logic [7:0] pd;
        push = (push_mode == 2) || (push_mode == 1 && $urandom_range(0, 2) == 0);
        pd   = 8'($urandom);
        cs = csv; mosi = b; s_axis_tvalid = push; s_axis_tdata = pd;
        @(posedge sclk);
        #1;
        edge_no++;
        flush = 0;
        if (rd) begin
            m_miso = model_read(ra);
            miso_q.push_back('{edge_no, m_miso});
        end
        if (wr) flush = model_write(wa, b);
        if (fwd) ax_q.push_back('{edge_no, fd, fu});
        if (flush) begin
            m_q.delete();
            m_ovf = 0;
        end else if (push) begin
            if (m_q.size() < RESULT_DEPTH) m_q.push_back(pd);
            else m_ovf = 1;
        end
        @(negedge sclk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic t_b(input logic [7:0] b);
        tick(0, b, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic t_cmd(input logic [7:0] b);
        if (b == 8'h01) tick(0, b, 0, 0, 0, 0, 1, 8'h01, 1);
        else if (b >= 8'h08 && m_en) tick(0, b, 0, 0, 0, 0, 1, b, 0);
        else t_b(b);
        if (b == 8'h04) m_en = 1;
        if (b == 8'h05) m_en = 0;
    endtask

    task automatic t_read(input logic [7:0] a);
        t_b(8'h02);
        tick(0, a, 1, a, 0, 0, 0, 0, 0);
    endtask

    task automatic t_write(input logic [7:0] a, input logic [7:0] d);
        t_b(8'h03);
        t_b(a);
        tick(0, d, 0, 0, 1, a, 0, 0, 0);
    endtask

    task automatic t_bread(input logic [7:0] a, input int n);
        int sz = area_size(a[7:6]);
        logic [7:0] ta;
        t_b(8'h06);
        t_b(a);
        if (n == 0) begin
            t_b(8'h00);
            miso_q.push_back('{edge_no, m_miso});
        end else begin
            for (int i = 0; i < n; i++) begin
                ta = {a[7:6], 6'((int'(a[5:0]) + i) % sz)};
                tick(0, (i == 0) ? 8'(n) : 8'($urandom), 1, ta, 0, 0, 0, 0, 0);
            end
        end
    endtask

    task automatic t_bwrite(input logic [7:0] a, input int n, input logic [7:0] d0, input bit rnd);
        int sz = area_size(a[7:6]);
        logic [7:0] ta;
        t_b(8'h07);
        t_b(a);
        t_b(8'(n));
        for (int i = 0; i < n; i++) begin
            ta = {a[7:6], 6'((int'(a[5:0]) + i) % sz)};
            tick(0, rnd ? 8'($urandom) : 8'(d0 + i), 0, 0, 1, ta, 0, 0, 0);
        end
    endtask

    task automatic check_regs(input string tag);
        logic [8*NUM_CHARS-1:0] ec, em;
        for (int i = 0; i < NUM_CHARS; i++) begin
            ec[8*i +: 8] = m_ch[i];
            em[8*i +: 8] = m_mk[i];
        end
        chk({tag, "_word_size"}, word_size, m_ws);
        chk({tag, "_result_mask"}, result_mask, m_rm);
        chk({tag, "_characters"}, characters, ec);
        chk({tag, "_masks"}, masks, em);
        chk({tag, "_aresetn"}, aresetn, m_en);
    endtask

    // Monitor: compares scheduled miso loads and every matcher stream beat.
    always @(negedge sclk) begin
        if (miso_q.size() > 0 && miso_q[0].e == edge_no) begin
            chk("miso", miso, miso_q[0].v);
            void'(miso_q.pop_front());
        end
        if (ax_q.size() > 0 && ax_q[0].e == edge_no) begin
            chk("axis_tvalid", m_axis_tvalid, 1'b1);
            chk("axis_tdata", m_axis_tdata, ax_q[0].d);
            chk("axis_tuser", m_axis_tuser, ax_q[0].u);
            void'(ax_q.pop_front());
        end else if (m_axis_tvalid === 1'b1) begin
            chk("axis_unexpected_tvalid", m_axis_tvalid, 1'b0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] a;
        int r, n;
        rst = 1'b1; cs = 1'b1; mosi = 8'h00; s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00;
        model_reset();
        repeat (2) @(posedge sclk);
        @(negedge sclk);
        rst = 1'b0;
        chk("rst_miso", miso, 8'h00);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tdata", m_axis_tdata, 8'h00);
        chk("rst_tuser", m_axis_tuser, 1'b0);
        check_regs("rst");

        t_read(8'h00);
        t_read(8'h02);

        t_bwrite(8'h46, 4, 8'hA1, 0);
        check_regs("bw46");
        t_bread(8'h46, 4);

        t_cmd(8'h04);
        t_cmd(8'h61);
        t_cmd(8'h62);
        t_cmd(8'h01);
        t_cmd(8'h05);
        t_cmd(8'h63);
        check_regs("stream");

        push_mode = 2;
        repeat (9) t_cmd(8'h00);
        push_mode = 0;
        t_read(8'h02);
        t_bread(8'hC0, 9);
        t_write(8'h03, 8'h01);
        t_read(8'h02);

        push_mode = 2;
        repeat (8) t_cmd(8'h00);
        push_mode = 0;
        t_b(8'h02);
        push_mode = 2;
        tick(0, 8'hC0, 1, 8'hC0, 0, 0, 0, 0, 0);
        push_mode = 0;
        t_read(8'h02);
        t_write(8'h03, 8'h01);

        t_cmd(8'h04);
        t_b(8'h03);
        t_b(8'h01);
        tick(1, 8'h77, 0, 0, 0, 0, 0, 0, 0);
        t_cmd(8'h55);
        t_bread(8'h41, 0);
        t_bwrite(8'h41, 0, 8'h00, 1);
        check_regs("abort");

        t_b(8'h07);
        t_b(8'h40);
        t_b(8'h03);
        tick(0, 8'h11, 0, 0, 1, 8'h40, 0, 0, 0);
        cs = 1'b0; mosi = 8'h22; rst = 1'b1;
        @(posedge sclk);
        #1;
        edge_no++;
        model_reset();
        @(negedge sclk);
        rst = 1'b0;
        chk("midrst_miso", miso, 8'h00);
        check_regs("midrst");
        t_read(8'h40);

        push_mode = 1;
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 6);
            a = 8'($urandom);
            if (a[7:6] == 2'b00) a[5:0] = 6'($urandom_range(0, 4));
            n = (a[7:6] == 2'b11) ? $urandom_range(0, 10) : $urandom_range(0, 5);
            case (r)
                0: t_read(a);
                1: t_write(a, 8'($urandom));
                2: t_bread(a, n);
                3: t_bwrite(a, n, 8'h00, 1);
                4: begin
                    t_b(8'h03);
                    t_b(a);
                    tick(1, 8'($urandom), 0, 0, 0, 0, 0, 0, 0);
                end
                default: begin
                    case ($urandom_range(0, 5))
                        0: t_cmd(8'h00);
                        1: t_cmd(8'h01);
                        2: t_cmd(8'h04);
                        3: t_cmd(8'h05);
                        default: t_cmd(8'(8 + $urandom_range(0, 247)));
                    endcase
                end
            endcase
            check_regs("rand");
        end
        push_mode = 0;
        t_read(8'h02);
        repeat (2) @(negedge sclk);
        chk("leftover_miso_expect", miso_q.size(), 0);
        chk("leftover_axis_expect", ax_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
